// File: rtl/icache_2way_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : icache_2way_pkg                                            |
// | Description : Shared constants, way enumeration and helper function for  |
// |               the two-way set-associative instruction cache.             |
// | Revision    : 1.0  initial release                                       |
// +--------------------------------------------------------------------------+
package icache_2way_pkg;

  localparam int          ICACHE_SETS   = 64;
  localparam int          ICACHE_IDX_W  = 6;
  localparam int          ICACHE_ADDR_W = 17;

  localparam logic        HIT           = 1'b1;
  localparam logic        MISS          = 1'b0;
  localparam logic        WRITE_ENABLE  = 1'b1;
  localparam logic        WRITE_DISABLE = 1'b0;
  localparam logic [31:0] ZERO_WORD     = 32'h0000_0000;

  // Way identifier; also the encoding of the per-set LRU bit.
  typedef enum logic {
    WAY0 = 1'b0,
    WAY1 = 1'b1
  } way_e;

  function automatic way_e other_way(input way_e w);
    return (w == WAY0) ? WAY1 : WAY0;
  endfunction

endpackage
`default_nettype wire

// File: rtl/icache_2way_if.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : icache_2way_if                                             |
// | Description : Lookup / fill / flush bundle between the IF stage and the  |
// |               instruction cache.                                         |
// |   master (IF) : drives re_i, raddr_i, we_i, waddr_i, winst_i, flush_i    |
// |   slave (cache): drives hit_o, inst_o                                    |
// | Revision    : 1.0  initial release                                       |
// +--------------------------------------------------------------------------+
interface icache_2way_if;
  logic        re_i;
  logic [31:0] raddr_i;
  logic        hit_o;
  logic [31:0] inst_o;
  logic        we_i;
  logic [31:0] waddr_i;
  logic [31:0] winst_i;
  logic        flush_i;

  modport master (
    output re_i, raddr_i, we_i, waddr_i, winst_i, flush_i,
    input  hit_o, inst_o
  );

  modport slave (
    input  re_i, raddr_i, we_i, waddr_i, winst_i, flush_i,
    output hit_o, inst_o
  );
endinterface
`default_nettype wire

// File: rtl/icache_2way_way.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : icache_way                                                 |
// | Description : One way of the cache: per-set valid bit, tag and 32-bit    |
// |               data, all in flops.                                        |
// |   rd_idx_i/rd_tag_i   -> rd_match_o, rd_data_o  (combinational lookup)   |
// |   wr_idx_i/wr_tag_i   -> wr_valid_o, wr_match_o (victim-select probe)    |
// |   we_i, wdata_i       : write the line at wr_idx_i (already qualified)   |
// |   flush_i, rst        : clear every valid bit; tags/data are kept        |
// | Revision    : 1.0  initial release                                       |
// +--------------------------------------------------------------------------+
module icache_way #(
  parameter int SETS  = 64,
  parameter int IDX_W = 6,
  parameter int TAG_W = 9
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [IDX_W-1:0] rd_idx_i,
  input  logic [TAG_W-1:0] rd_tag_i,
  input  logic [IDX_W-1:0] wr_idx_i,
  input  logic [TAG_W-1:0] wr_tag_i,
  input  logic             we_i,
  input  logic [31:0]      wdata_i,
  input  logic             flush_i,
  output logic             rd_match_o,
  output logic [31:0]      rd_data_o,
  output logic             wr_valid_o,
  output logic             wr_match_o
);

  logic [SETS-1:0]  valid_q, valid_d;
  logic [TAG_W-1:0] tag_q  [SETS];
  logic [TAG_W-1:0] tag_d  [SETS];
  logic [31:0]      data_q [SETS];
  logic [31:0]      data_d [SETS];

  always_comb begin
    valid_d = valid_q;
    tag_d   = tag_q;
    data_d  = data_q;
    if (rst || flush_i) begin
      valid_d = '0;
    end else if (we_i) begin
      valid_d[wr_idx_i] = 1'b1;
    end
    if (we_i) begin
      tag_d[wr_idx_i]  = wr_tag_i;
      data_d[wr_idx_i] = wdata_i;
    end
  end

  always_ff @(posedge clk) begin
    valid_q <= valid_d;
  end

  // Tags and data carry no reset: a line is only observable once valid.
  always_ff @(posedge clk) begin
    tag_q  <= tag_d;
    data_q <= data_d;
  end

  assign rd_match_o = valid_q[rd_idx_i] && (tag_q[rd_idx_i] == rd_tag_i);
  assign rd_data_o  = data_q[rd_idx_i];
  assign wr_valid_o = valid_q[wr_idx_i];
  assign wr_match_o = valid_q[wr_idx_i] && (tag_q[wr_idx_i] == wr_tag_i);

endmodule
`default_nettype wire

// File: rtl/icache_2way.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : icache_2way                                                |
// | Description : Two-way set-associative instruction cache with one LRU bit |
// |               per set, combinational lookup and same-cycle write bypass. |
// |   clk, rst : clock, synchronous active-high reset                        |
// |   bus      : icache_2way_if.slave (lookup, fill, flush)                  |
// |   hit_cnt_o, miss_cnt_o : lookup statistics, present only when the       |
// |                           ICACHE_STATS_EN macro is defined               |
// | Revision    : 1.0  initial release                                       |
// +--------------------------------------------------------------------------+
module icache_2way
  import icache_2way_pkg::*;
#(
  parameter int SETS   = ICACHE_SETS,
  parameter int IDX_W  = ICACHE_IDX_W,
  parameter int ADDR_W = ICACHE_ADDR_W
) (
  input  logic          clk,
  input  logic          rst,
  icache_2way_if.slave  bus
`ifdef ICACHE_STATS_EN
  ,
  output logic [31:0]   hit_cnt_o,
  output logic [31:0]   miss_cnt_o
`endif
);

  localparam int TAG_W = ADDR_W - IDX_W - 2;

  logic [IDX_W-1:0] r_idx, w_idx;
  logic [TAG_W-1:0] r_tag, w_tag;

  assign r_idx = bus.raddr_i[IDX_W+1:2];
  assign r_tag = bus.raddr_i[ADDR_W-1:IDX_W+2];
  assign w_idx = bus.waddr_i[IDX_W+1:2];
  assign w_tag = bus.waddr_i[ADDR_W-1:IDX_W+2];

  // Byte-offset bits and bits above ADDR_W take no part in lookup.
  logic addr_unused;
  assign addr_unused = ^{bus.raddr_i[31:ADDR_W], bus.raddr_i[1:0],
                         bus.waddr_i[31:ADDR_W], bus.waddr_i[1:0]};

  logic [1:0]  rd_match, wr_valid, wr_match, way_we;
  logic [31:0] rd_data [2];

  for (genvar w = 0; w < 2; w++) begin : g_way
    icache_way #(
      .SETS  (SETS),
      .IDX_W (IDX_W),
      .TAG_W (TAG_W)
    ) u_way (
      .clk        (clk),
      .rst        (rst),
      .rd_idx_i   (r_idx),
      .rd_tag_i   (r_tag),
      .wr_idx_i   (w_idx),
      .wr_tag_i   (w_tag),
      .we_i       (way_we[w]),
      .wdata_i    (bus.winst_i),
      .flush_i    (bus.flush_i),
      .rd_match_o (rd_match[w]),
      .rd_data_o  (rd_data[w]),
      .wr_valid_o (wr_valid[w]),
      .wr_match_o (wr_match[w])
    );
  end

  logic [SETS-1:0] lru_q, lru_d;
  logic            fill, bypass, arr_hit;
  way_e            hit_way, victim;

  // A fill coinciding with flush or reset is dropped.
  assign fill    = bus.we_i & ~bus.flush_i & ~rst;
  assign bypass  = bus.we_i & (w_idx == r_idx) & (w_tag == r_tag);
  assign arr_hit = |rd_match;
  assign hit_way = rd_match[1] ? WAY1 : WAY0;

  // Victim: matching line first (no duplicate tags), then an empty way,
  // then the way the LRU bit names.
  always_comb begin
    victim = way_e'(lru_q[w_idx]);
    if (wr_match[0]) begin
      victim = WAY0;
    end else if (wr_match[1]) begin
      victim = WAY1;
    end else if (!wr_valid[0]) begin
      victim = WAY0;
    end else if (!wr_valid[1]) begin
      victim = WAY1;
    end
  end

  always_comb begin
    way_we = {WRITE_DISABLE, WRITE_DISABLE};
    if (fill) begin
      if (victim == WAY1) way_we[1] = WRITE_ENABLE;
      else                way_we[0] = WRITE_ENABLE;
    end
  end

  always_comb begin
    bus.hit_o  = MISS;
    bus.inst_o = ZERO_WORD;
    if (!rst && !bus.flush_i) begin
      if (bypass) begin
        bus.hit_o  = HIT;
        bus.inst_o = bus.winst_i;
      end else if (arr_hit) begin
        bus.hit_o  = HIT;
        bus.inst_o = (hit_way == WAY1) ? rd_data[1] : rd_data[0];
      end
    end
  end

  // Fill update is applied last so it overrides a read update to the same set.
  always_comb begin
    lru_d = lru_q;
    if (rst) begin
      lru_d = '0;
    end else begin
      if (bus.re_i && !bus.flush_i && arr_hit && !bypass) begin
        lru_d[r_idx] = other_way(hit_way);
      end
      if (fill) begin
        lru_d[w_idx] = other_way(victim);
      end
    end
  end

  always_ff @(posedge clk) begin
    lru_q <= lru_d;
  end

`ifdef ICACHE_STATS_EN
  logic [31:0] hit_cnt_q, hit_cnt_d, miss_cnt_q, miss_cnt_d;

  always_comb begin
    hit_cnt_d  = hit_cnt_q;
    miss_cnt_d = miss_cnt_q;
    if (rst) begin
      hit_cnt_d  = '0;
      miss_cnt_d = '0;
    end else if (bus.re_i) begin
      if (bus.hit_o) begin
        if (hit_cnt_q != 32'hFFFF_FFFF) hit_cnt_d = hit_cnt_q + 32'd1;
      end else begin
        if (miss_cnt_q != 32'hFFFF_FFFF) miss_cnt_d = miss_cnt_q + 32'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    hit_cnt_q  <= hit_cnt_d;
    miss_cnt_q <= miss_cnt_d;
  end

  assign hit_cnt_o  = hit_cnt_q;
  assign miss_cnt_o = miss_cnt_q;
`endif

endmodule
`default_nettype wire

// File: doc/icache_2way.md
Name: icache_2way

Overview:
- Two-way set-associative instruction cache feeding the IF stage.
- IF presents a registered read address and samples hit/instruction on the following cycle. On a miss, IF assembles the word from byte-wide memory and writes it back through the write port.
- Lookup is combinational from the array flops, so IF sees the result in the same cycle the address is stable.
- Replacement is one LRU bit per set.

Parameters:
- SETS, 64, number of sets; power of two, at least 2.
- IDX_W, 6, log2(SETS).
- ADDR_W, 17, significant byte-address bits; bits above are ignored for tag compare.
- TAG_W, ADDR_W-IDX_W-2, tag width (derived; not overridden).

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- re_i  in  1  lookup qualifier; asserted by IF while waiting on a lookup; gates LRU update and statistics
- raddr_i  in  32  lookup byte address, word aligned
- hit_o  out  1  1 = hit
- inst_o  out  32  instruction on hit; 0 on miss
- we_i  in  1  fill strobe, one cycle per fill
- waddr_i  in  32  fill byte address
- winst_i  in  32  fill data
- flush_i  in  1  invalidate all lines (fence.i / redirect cleanup)

Behaviour:
- Address split: index = addr[IDX_W+1:2]; tag = addr[ADDR_W-1:IDX_W+2]; addr[1:0] ignored.
- Per set, per way: valid bit, tag, 32-bit data. Per set: one lru bit naming the way to replace next. All storage is flops.
- Lookup is combinational; no latency.
  - hit_o = 1 if either way in set idx(raddr_i) is valid with a matching tag.
  - inst_o = that way's data. Both ways matching is impossible by construction.
- Write bypass: if we_i and idx/tag of waddr_i equal those of raddr_i in the same cycle, then hit_o = 1 and inst_o = winst_i, regardless of array state.
- Fill on clk edge with we_i = 1 and flush_i = 0, set s = idx(waddr_i); way selection in priority order:
  - a valid way with matching tag is overwritten (no duplicates);
  - otherwise invalid way 0, then invalid way 1;
  - otherwise way lru[s].
  - Written way becomes valid; lru[s] <= other way.
- Read LRU update: on clk edge with re_i = 1, an array hit (not the bypass), and no fill to the same set, lru[s] <= the way not hit. If a fill targets the same set, the fill's LRU update wins.
- Flush: flush_i = 1 clears all valid bits at the edge; lru is untouched. A simultaneous we_i is dropped, and hit_o is forced to 0 in the flush cycle.
- Reset: while rst = 1, hit_o = 0 and inst_o = 0 (combinationally forced). At the edge, all valid and lru bits clear. Tags and data are not reset.
- Reset or flush mid-miss: the IF fill arriving later is accepted normally as a fresh fill.
- Idle (re_i = 0, we_i = 0): no state change.

Optional Feature:
- Macro: ICACHE_STATS_EN.
- With the macro defined, add outputs hit_cnt_o (32) and miss_cnt_o (32):
  - on each edge with re_i = 1, increment hit_cnt_o if hit_o else miss_cnt_o;
  - counters saturate at 32'hFFFFFFFF;
  - cleared by rst only, not by flush_i;
  - a bypass hit counts as a hit.
- Without the macro: ports absent, no counter logic.

Decomposition:
- defines.v: IcacheSets, IcacheIdxW, IcacheAddrW, Hit/Miss, WriteEnable/WriteDisable, ZeroWord.
- Sub-module icache_way: one way's valid/tag/data arrays.
  - Inputs: index, tag, write enable, data, flush.
  - Outputs: match and data for the lookup index.
- Top icache_2way: instantiates two ways and owns LRU, victim select, bypass and stats.

Test Plan:
- Reset, then lookup raddr 0x0000 with re_i = 1 -> hit_o = 0, inst_o = 0; with stats, miss_cnt_o = 1 after the edge.
- Fill 0x0100 with 0x00500093, next cycle lookup 0x0100 -> hit_o = 1, inst_o = 0x00500093; lookup 0x0102 -> same (low bits ignored).
- Fill 0x0100, 0x1100 and 0x2100 (same set, SETS = 64):
  - 0x0100 goes to way 0, 0x1100 to way 1;
  - read-hit 0x0100 sets lru = way 1;
  - fill 0x2100 evicts 0x1100, so lookup 0x1100 misses and 0x0100 and 0x2100 hit.
- Same cycle we_i = 1 with waddr = raddr = 0x0200, winst = 0xDEADBEEF -> hit_o = 1, inst_o = 0xDEADBEEF in that cycle; hit persists next cycle.
- Fill 0x0300, then flush_i = 1 together with we_i for 0x0400 -> afterwards both 0x0300 and 0x0400 miss.
- Assert rst for one cycle after several fills -> all lookups miss; with stats, both counters read 0.
